// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the four-digit seven-segment
// scanner. Segment patterns are active-low, bit order gfedcba (bit 0 = a).
package seg_scan_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   localparam logic [6:0] HEX_0 = 7'b1000000;
   localparam logic [6:0] HEX_1 = 7'b1111001;
   localparam logic [6:0] HEX_2 = 7'b0100100;
   localparam logic [6:0] HEX_3 = 7'b0110000;
   localparam logic [6:0] HEX_4 = 7'b0011001;
   localparam logic [6:0] HEX_5 = 7'b0010010;
   localparam logic [6:0] HEX_6 = 7'b0000010;
   localparam logic [6:0] HEX_7 = 7'b1111000;
   localparam logic [6:0] HEX_8 = 7'b0000000;
   localparam logic [6:0] HEX_9 = 7'b0010000;
   localparam logic [6:0] HEX_A = 7'b0001000;
   localparam logic [6:0] HEX_B = 7'b0000011;
   localparam logic [6:0] HEX_C = 7'b1000110;
   localparam logic [6:0] HEX_D = 7'b0100001;
   localparam logic [6:0] HEX_E = 7'b0000110;
   localparam logic [6:0] HEX_F = 7'b0001110;

   // Digit index: 0 = rightmost (an[0]) .. 3 = leftmost (an[3]).
   typedef logic [1:0] digit_t;
   localparam digit_t DIGIT_LAST = 2'd3;

endpackage

// File: rtl/seg_scan_hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decoder.
//   nib  in  4  hex digit 0..F
//   seg  out 7  active-low segments, seg[0]=a .. seg[6]=g
module hex7seg
   import seg_scan_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = HEX_0;
         4'h1: seg = HEX_1;
         4'h2: seg = HEX_2;
         4'h3: seg = HEX_3;
         4'h4: seg = HEX_4;
         4'h5: seg = HEX_5;
         4'h6: seg = HEX_6;
         4'h7: seg = HEX_7;
         4'h8: seg = HEX_8;
         4'h9: seg = HEX_9;
         4'hA: seg = HEX_A;
         4'hB: seg = HEX_B;
         4'hC: seg = HEX_C;
         4'hD: seg = HEX_D;
         4'hE: seg = HEX_E;
         4'hF: seg = HEX_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: four-digit seven-segment scanner. Time-multiplexes a 16-bit hex
// value onto one segment bus and one anode bus with per-digit blanking,
// leading-zero suppression and an anti-ghost dead time at each slot start.
// The value/blank/lz inputs are captured once per frame (on the digit 3 -> 0
// wrap) so a frame never mixes old and new data.
//   clk          in  1   system clock, rising edge
//   rst_n        in  1   synchronous reset, active-low
//   en           in  1   scan enable; 0 = dark and frozen
//   value        in  16  hex value, nibble k on digit k
//   blank        in  4   per-digit force blank
//   lz_suppress  in  1   blank leading zero digits (never digit 0)
//   seg          out 7   active-low segments (registered)
//   an           out 4   active-low anodes (registered)
//   frame_tick   out 1   one-cycle pulse after a frame capture
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int DEAD     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  blank,
   input  logic        lz_suppress,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] cnt;
   digit_t        dig, dig_nxt;
   logic          term, wrap_frame, in_dead;

   logic [15:0]   sh_value;
   logic [3:0]    sh_blank;
   logic          sh_lz;

   logic [3:0]    nib;
   logic [6:0]    dec;
   logic [3:0]    lz_vec, blank_vec;
   logic          z3, z2, z1;

   logic [6:0]    seg_d;
   logic [3:0]    an_d;
   logic          tick_d;

   assign term       = (cnt == CW'(PRESCALE - 1));
   // A disabled cycle never advances, so a terminal count coinciding with
   // en falling neither wraps the digit nor captures.
   assign wrap_frame = en && term && (dig == DIGIT_LAST);

   generate
      if (DEAD == 0) begin : g_nodead
         assign in_dead = 1'b0;
      end else begin : g_dead
         assign in_dead = (cnt < CW'(DEAD));
      end
   endgenerate

   // Slot counter
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (en)
         cnt <= term ? '0 : cnt + CW'(1);
   end

   // Digit FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         dig <= '0;
      else
         dig <= dig_nxt;
   end

   // Digit FSM: next state
   always_comb begin
      dig_nxt = dig;
      if (en && term)
         dig_nxt = dig + digit_t'(1);
   end

   // Shadow registers track the inputs continuously while disabled so the
   // first frame after enabling shows current data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_value <= '0;
         sh_blank <= '0;
         sh_lz    <= 1'b0;
      end else if (!en || wrap_frame) begin
         sh_value <= value;
         sh_blank <= blank;
         sh_lz    <= lz_suppress;
      end
   end

   // Leading-zero detect: digit k is suppressed when nibbles k..3 are all zero.
   assign z3        = (sh_value[15:12] == 4'h0);
   assign z2        = z3 && (sh_value[11:8] == 4'h0);
   assign z1        = z2 && (sh_value[7:4] == 4'h0);
   assign lz_vec    = {z3, z2, z1, 1'b0} & {4{sh_lz}};
   assign blank_vec = sh_blank | lz_vec;

   assign nib = sh_value[{dig, 2'b00} +: 4];

   hex7seg u_dec (
      .nib (nib),
      .seg (dec)
   );

   // Digit FSM: outputs (registered below for a clean one-cycle latency)
   always_comb begin
      seg_d  = SEG_BLANK;
      an_d   = AN_OFF;
      tick_d = 1'b0;
      if (en) begin
         seg_d  = blank_vec[dig] ? SEG_BLANK : dec;
         an_d   = in_dead ? AN_OFF : ~(4'b0001 << dig);
         tick_d = wrap_frame;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg        <= SEG_BLANK;
         an         <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_d;
         an         <= an_d;
         frame_tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with PRESCALE=4, DEAD=1.
// Each frame is 16 cycles: per digit one dark dead cycle then three lit cycles.
module tb_seg_scan;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S8 = 7'b0000000, SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SX = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] value;
   logic [3:0]  blank;
   logic        lz_suppress;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   int ncmp = 0;
   int nerr = 0;

   seg_scan #(.PRESCALE(4), .DEAD(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .value       (value),
      .blank       (blank),
      .lz_suppress (lz_suppress),
      .seg         (seg),
      .an          (an),
      .frame_tick  (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Checks one full frame starting at digit 0 slot 0. Optionally changes
   // the inputs at the start of digit chg_d; they must not show until the
   // following frame.
   task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3,
                              input int chg_d, input logic [15:0] nv,
                              input logic [3:0] nb, input logic nlz);
      logic [6:0] es [4];
      logic [3:0] ea;
      es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
      for (int d = 0; d < 4; d++) begin
         for (int s = 0; s < 4; s++) begin
            if (d == chg_d && s == 0) begin
               value       = nv;
               blank       = nb;
               lz_suppress = nlz;
            end
            tick();
            ea = 4'b0001 << d;
            ea = (s == 0) ? 4'b1111 : ~ea;
            chk($sformatf("an d%0d s%0d", d, s), {3'b000, an}, {3'b000, ea});
            chk($sformatf("seg d%0d s%0d", d, s), seg, es[d]);
            chk($sformatf("tick d%0d s%0d", d, s), {6'b0, frame_tick},
                {6'b0, (d == 3 && s == 3)});
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; value = 16'h1234; blank = 4'b0000; lz_suppress = 1'b0;
      tick(); tick();
      chk("rst seg", seg, SX);
      chk("rst an", {3'b000, an}, 7'h0F);
      chk("rst tick", {6'b0, frame_tick}, 7'h00);
      rst_n = 1'b1;

      // Shadow is zero until the first capture.
      check_frame(S0, S0, S0, S0, -1, 16'h0, 4'h0, 1'b0);
      // 1234 frame; ABCD applied mid-frame at digit 1.
      check_frame(S4, S3, S2, S1, 1, 16'hABCD, 4'h0, 1'b0);
      check_frame(SD, SC, SB, SA, 0, 16'h0005, 4'h0, 1'b1);
      // Leading-zero suppression.
      check_frame(S5, SX, SX, SX, 2, 16'h0000, 4'h0, 1'b1);
      check_frame(S0, SX, SX, SX, 0, 16'h8888, 4'b0101, 1'b0);
      // Forced blanking of digits 0 and 2.
      check_frame(SX, S8, SX, S8, 0, 16'h1234, 4'h0, 1'b0);

      // Run to the terminal count of digit 2, then drop en.
      for (int j = 0; j < 11; j++) tick();
      chk("pre-hold an", {3'b000, an}, 7'b0001011);
      chk("pre-hold seg", seg, S2);
      en = 1'b0;
      tick();
      chk("hold an", {3'b000, an}, 7'h0F);
      chk("hold seg", seg, SX);
      chk("hold tick", {6'b0, frame_tick}, 7'h00);
      for (int j = 0; j < 9; j++) tick();
      chk("hold10 an", {3'b000, an}, 7'h0F);
      chk("hold10 tick", {6'b0, frame_tick}, 7'h00);
      en = 1'b1;
      tick();
      chk("resume an", {3'b000, an}, 7'b0001011);
      chk("resume seg", seg, S2);
      chk("resume tick", {6'b0, frame_tick}, 7'h00);
      tick();
      chk("resume d3 dead an", {3'b000, an}, 7'h0F);
      chk("resume d3 seg", seg, S1);
      tick(); tick(); tick();
      chk("resume d3 an", {3'b000, an}, 7'b0000111);
      chk("resume wrap tick", {6'b0, frame_tick}, 7'h01);

      // Reset in the middle of digit 3.
      for (int j = 0; j < 14; j++) tick();
      chk("pre-rst an", {3'b000, an}, 7'b0000111);
      chk("pre-rst seg", seg, S1);
      rst_n = 1'b0;
      tick();
      chk("midrst seg", seg, SX);
      chk("midrst an", {3'b000, an}, 7'h0F);
      chk("midrst tick", {6'b0, frame_tick}, 7'h00);
      rst_n = 1'b1;
      check_frame(S0, S0, S0, S0, -1, 16'h0, 4'h0, 1'b0);
      check_frame(S4, S3, S2, S1, -1, 16'h0, 4'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Four-digit seven-segment scanner that sits directly upstream of the display multiplexer.
- Takes a 16-bit hex value and time-multiplexes it onto one segment bus and one anode bus, with per-digit blanking, leading-zero suppression and anti-ghost dead time.
- Its seg/an outputs feed one segment/anode input pair of the display multiplexer; the mode selection happens there.
- The displayed value is captured once per scan frame, so a digit can never show half of an old value and half of a new one.

Parameters:
PRESCALE, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
DEAD, 2, cycles at the start of each slot during which all anodes are off; legal range 0..PRESCALE-1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  synchronous reset, active-low.
en  in  1  scan enable; 0 = display dark and scan frozen.
value  in  16  hex value; nibble k is shown on digit k (digit 0 = rightmost = an[0]).
blank  in  4  per-digit force-blank; bit k blanks digit k.
lz_suppress  in  1  1 = blank leading zero digits.
seg  out  7  segment drive, active-low; seg[0]=a .. seg[6]=g.
an  out  4  anode drive, active-low, one-hot-low when a digit is lit.
frame_tick  out  1  one-cycle pulse when a new frame's inputs are captured.

Behaviour:
- Reset (rst_n=0 at a clk edge): seg=7'b1111111, an=4'b1111, frame_tick=0, slot counter=0, digit=0, shadow value/blank/lz=0. Reset overrides en.
- Slot counter: counts 0..PRESCALE-1 while en=1. At terminal count it wraps to 0 and digit advances 0→1→2→3→0.
- Capture: the wrap from digit 3 to digit 0 loads shadow_value, shadow_blank and shadow_lz from the inputs in the same edge. frame_tick=1 for exactly the following cycle.
- Capture while disabled: while en=0, the shadow registers reload every cycle, so the first frame after enabling shows current data.
- Input timing: inputs are sampled only at capture edges; changes mid-frame have no effect until the next capture.
- Output latency: seg/an are registered and reflect the counter/digit state of the previous cycle (1-cycle latency).
- Dead time: an=4'b1111 while slot count < DEAD. Otherwise an = ~(4'b0001 << digit). seg always carries the decode for the current digit, and is forced 7'b1111111 when the digit is blanked.
- Blanking of a digit k: set if shadow_blank[k]=1, or if shadow_lz=1 and nibbles k..3 are all zero and k != 0. Digit 0 is never zero-suppressed (value 0 shows "0"). A digit blanked this way keeps its anode active and drives seg=1111111.
- Decode (active-low, gfedcba), hex 0-F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- en=0: counter and digit hold. Next cycle seg=1111111, an=1111, frame_tick=0. On re-enable the scan resumes from the held counter/digit; no frame_tick is issued for resumption.
- en falling in the same cycle as a terminal count: the hold wins; no advance, no capture, no frame_tick.
- Reset mid-frame: everything returns to reset values on that edge; no partial frame_tick.
- Terminal-count compare is on an exact match with PRESCALE-1; the counter width is clog2(PRESCALE).

Decomposition:
- Shared package: SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111, AN_OFF=4'b1111, the hex decode constants, and a digit-index typedef (2 bits).
- One sub-module, hex7seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected shadow nibble.
- Counter, digit FSM, shadow registers and blank logic stay in seg_scan.

Test Plan (PRESCALE=4, DEAD=1):
- Reset release, en=1, value=16'h1234 -> after first capture: per 4-cycle slot, an=1111 for 1 cycle then 1110 with seg=0011001 ("4"), then 1101/0110000 ("3"), 1011/0100100, 0111/1111001. frame_tick pulses every 16 cycles.
- value changed 16'h1234→16'hABCD mid-frame at digit 1 -> digits 2,3 still show 2,1. The next frame shows d,C,b,A. frame_tick coincides with the switch.
- lz_suppress=1, value=16'h0005 -> digit0 seg=0010010, digits1-3 seg=1111111 with anodes still cycling; value=16'h0000 -> digit0 shows 1000000.
- blank=4'b0101, value=16'h8888 -> digits 0,2 seg=1111111, digits 1,3 seg=0000000.
- en dropped at a terminal count of digit 2 -> next cycle an=1111, seg=1111111, no frame_tick. Re-enable 10 cycles later -> resumes digit 2 slot from the held count.
- rst_n=0 for one cycle mid-slot of digit 3 -> next cycle seg=1111111, an=1111, frame_tick=0. Scan restarts at digit 0, and the shadow value is 0 until the first capture.
